regfile_wb_arbiter: RTL and testbench

- Shares the integer register file's single write port between NUM_REQ writeback sources (ALU, LSU, MUL/DIV by default).
- Round-robin arbitration with a valid/ready handshake per source; one write is issued per cycle through a registered output stage.
- Sits between the execute/writeback units and the architectural integer register file write port (address, enable, data).
- Filters writes to x0 and keeps a saturating contention counter for performance debug.

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_rr_arbiter_comb.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and constants for the integer register file writeback arbiter.
// Also holds the "two or more requesters" helper used by the contention counter.
package regfile_wb_arbiter_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int REG_ZERO    = 0;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MUL = 2;

    // Clearing the lowest set bit leaves something behind only when two or more bits were set.
    function automatic logic multiple_set(input logic [7:0] mask);
        return (mask & (mask - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter_comb.sv
// Purely combinational round-robin picker: the first eligible source at or after
// the pointer (wrapping) wins, reported both one-hot and as an index.
module rr_arbiter_comb #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grantIdx,
    output logic               o_grantValid
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant      = '0;
        o_grantIdx   = '0;
        o_grantValid = 1'b0;
        w_found      = 1'b0;
        w_idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && i_eligible[w_idx]) begin
                w_found         = 1'b1;
                o_grant[w_idx]  = 1'b1;
                o_grantIdx      = PTR_W'(w_idx);
            end
        end
        o_grantValid = w_found;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between NUM_REQ writeback sources with
// round-robin arbitration, x0 filtering and a saturating contention counter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    output logic                      wb_we,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic [CNT_W-1:0]          contention_cnt
);

    localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_zeroReq;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_grantIdx;
    logic               w_grantValid;
    logic [ADDR_W-1:0]  w_grantAddr;
    logic [DATA_W-1:0]  w_grantData;
    logic               w_contend;

    logic [PTR_W-1:0]   r_rrPtr;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_cnt;

    // x0 writes are acknowledged immediately, even under hold, and never compete.
    always_comb begin
        w_eligible = '0;
        w_zeroReq  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)) begin
                w_zeroReq[i] = req_valid[i];
            end else begin
                w_eligible[i] = req_valid[i] && !wb_hold;
            end
        end
    end

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rrArbiter (
        .i_eligible   (w_eligible),
        .i_ptr        (r_rrPtr),
        .o_grant      (w_grant),
        .o_grantIdx   (w_grantIdx),
        .o_grantValid (w_grantValid)
    );

    always_comb begin
        w_grantAddr = '0;
        w_grantData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grantAddr = req_addr[i*ADDR_W +: ADDR_W];
                w_grantData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_contend = multiple_set(8'(w_eligible));
    assign req_ready = reset ? '0 : (w_grant | w_zeroReq);

    // Address/data keep their last value when idle; only the enable drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_we <= w_grantValid;
            if (w_grantValid) begin
                r_addr  <= w_grantAddr;
                r_data  <= w_grantData;
                r_rrPtr <= (w_grantIdx == LAST_IDX) ? '0 : w_grantIdx + PTR_W'(1);
            end
            if (w_contend && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_we          = r_we;
    assign wb_addr        = r_addr;
    assign wb_data        = r_data;
    assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes hand-computed writes into a
// scoreboard queue, and a negedge monitor pops and compares every presented write.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wb_hold;
    logic                      wb_we;
    logic [ADDR_W-1:0]         wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic [CNT_W-1:0]          contention_cnt;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t expQ[$];
    wr_t monExp;
    int  checks = 0;
    int  errors = 0;

    regfile_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .wb_hold        (wb_hold),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v,
                                 input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic hold);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
        wb_hold   = hold;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    // One request cycle: drive after the edge, check the combinational ready mid-cycle.
    task automatic driveCycle(input string name, input logic [2:0] v,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic hold, input logic [2:0] expReady);
        applyStimulus(v, a0, a1, a2, d0, d1, d2, hold);
        @(negedge clk);
        checkOutput(name, 32'(req_ready), 32'(expReady));
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Every presented write must be the oldest expected one; anything else is unexpected.
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", wb_addr, wb_data);
            end else begin
                monExp = expQ.pop_front();
                if (wb_addr !== monExp.addr || wb_data !== monExp.data) begin
                    errors++;
                    $display("[TB] FAIL write_order: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                             wb_addr, wb_data, monExp.addr, monExp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rst_we", 32'(wb_we), 32'd0);
        checkOutput("rst_addr", 32'(wb_addr), 32'd0);
        checkOutput("rst_data", wb_data, 32'd0);
        checkOutput("rst_cnt", 32'(contention_cnt), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single request");
        expectWrite(5'd5, 32'hDEADBEEF);
        driveCycle("t1_ready", 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 3'b001);
        idleCycle();

        $display("[TB] full contention");
        expectWrite(5'd4, 32'h44);
        driveCycle("t2_align", 3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h44, 1'b0, 3'b100);
        expectWrite(5'd1, 32'h11);
        expectWrite(5'd2, 32'h22);
        expectWrite(5'd3, 32'h33);
        driveCycle("t2_grant0", 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 3'b001);
        driveCycle("t2_grant1", 3'b110, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 3'b010);
        driveCycle("t2_grant2", 3'b100, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 3'b100);
        checkOutput("t2_cnt", 32'(contention_cnt), 32'd2);

        $display("[TB] x0 filter");
        expectWrite(5'd7, 32'h77);
        driveCycle("t3_ready", 3'b110, 5'd0, 5'd0, 5'd7, 32'h0, 32'h55, 32'h77, 1'b0, 3'b110);
        expectWrite(5'd10, 32'hA0);
        driveCycle("t3_ptr0", 3'b011, 5'd10, 5'd11, 5'd0, 32'hA0, 32'hB0, 32'h0, 1'b0, 3'b001);
        expectWrite(5'd11, 32'hB0);
        driveCycle("t3_lsu", 3'b010, 5'd10, 5'd11, 5'd0, 32'hA0, 32'hB0, 32'h0, 1'b0, 3'b010);
        checkOutput("t3_cnt", 32'(contention_cnt), 32'd3);

        $display("[TB] hold");
        for (int i = 0; i < 4; i++) begin
            driveCycle("t4_hold_ready", 3'b011, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b1, 3'b010);
        end
        checkOutput("t4_hold_we", 32'(wb_we), 32'd0);
        expectWrite(5'd9, 32'h99);
        driveCycle("t4_release", 3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 3'b001);
        checkOutput("t4_we", 32'(wb_we), 32'd1);
        checkOutput("t4_cnt", 32'(contention_cnt), 32'd3);

        $display("[TB] saturation");
        for (int k = 0; k < 22; k++) begin
            automatic int src = (1 + k) % 3;
            expectWrite(5'(13 + src), 32'(32'h100 + src));
            driveCycle("t5_ready", 3'b111, 5'd13, 5'd14, 5'd15, 32'h100, 32'h101, 32'h102, 1'b0, 3'(1 << src));
            if (k == 19) begin
                checkOutput("t5_cnt_sat", 32'(contention_cnt), 32'hF);
            end
        end
        checkOutput("t5_cnt_hold", 32'(contention_cnt), 32'hF);

        $display("[TB] reset mid-operation");
        driveCycle("t6_grant", 3'b001, 5'd12, 5'd0, 5'd0, 32'h12C, 32'h0, 32'h0, 1'b0, 3'b001);
        reset = 1'b1;
        #1;
        checkOutput("t6_we", 32'(wb_we), 32'd0);
        checkOutput("t6_addr", 32'(wb_addr), 32'd0);
        checkOutput("t6_data", wb_data, 32'd0);
        checkOutput("t6_cnt", 32'(contention_cnt), 32'd0);
        @(negedge clk);
        checkOutput("t6_ready_rst", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("t6_cnt_rel", 32'(contention_cnt), 32'd0);
        @(posedge clk);
        #1;
        expectWrite(5'd20, 32'h200);
        driveCycle("t6_ptr0", 3'b110, 5'd0, 5'd20, 5'd21, 32'h0, 32'h200, 32'h210, 1'b0, 3'b010);
        expectWrite(5'd21, 32'h210);
        driveCycle("t6_mul", 3'b100, 5'd0, 5'd20, 5'd21, 32'h0, 32'h200, 32'h210, 1'b0, 3'b100);
        checkOutput("t6_cnt_after", 32'(contention_cnt), 32'd1);
        idleCycle();
        idleCycle();
        checkOutput("drain", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
